// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// States, opcode classes, datapath mux encodings and ALU codes.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_ALU,
        EXEC_SH,
        WB,
        MEM_RD,
        LD_WB,
        MEM_WR,
        BR_CALC,
        BR_LOAD
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_ITYPE,
        C_SH_REG,
        C_SH_IMM,
        C_LUI,
        C_LOAD,
        C_STOR,
        C_JCOND,
        C_JAL,
        C_SCOND,
        C_BCOND,
        C_ILLEGAL
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [4:0] alu_op;
    } decode_t;

    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_SHIFT   = 4'b1000;
    localparam logic [3:0] OP_BCOND   = 4'b1100;
    localparam logic [3:0] OP_LUI     = 4'b1111;

    localparam logic [3:0] EXT_LOAD   = 4'b0000;
    localparam logic [3:0] EXT_STOR   = 4'b0100;
    localparam logic [3:0] EXT_JAL    = 4'b1000;
    localparam logic [3:0] EXT_JCOND  = 4'b1100;
    localparam logic [3:0] EXT_SCOND  = 4'b1101;
    localparam logic [3:0] EXT_SH_REG = 4'b0100;

    localparam logic [4:0] ALU_ADD = 5'b00101;
    localparam logic [4:0] ALU_CMP = 5'b01011;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_LOAD = 2'b10;
    localparam logic [1:0] PC_ADD  = 2'b11;

    localparam logic [1:0] AIN_PC   = 2'b00;
    localparam logic [1:0] AIN_REG  = 2'b01;
    localparam logic [1:0] AIN_JTGT = 2'b11;

    localparam logic [1:0] OUT_SHIFT = 2'b00;
    localparam logic [1:0] OUT_ALU   = 2'b01;
    localparam logic [1:0] OUT_COND  = 2'b10;

    localparam logic [1:0] RF_MEM  = 2'b00;
    localparam logic [1:0] RF_OUT  = 2'b01;
    localparam logic [1:0] RF_LINK = 2'b10;

    localparam logic [1:0] IMM_SEXT  = 2'b00;
    localparam logic [1:0] IMM_SHAMT = 2'b01;
    localparam logic [1:0] IMM_UPPER = 2'b10;

    localparam logic [1:0] AMT_REG = 2'b00;
    localparam logic [1:0] AMT_IMM = 2'b01;
    localparam logic [1:0] AMT_LUI = 2'b10;

    localparam logic [1:0] SHF_REG = 2'b00;
    localparam logic [1:0] SHF_IMM = 2'b01;

    // First state after DECODE for each instruction class.
    function automatic state_t exec_state(iclass_t c);
        state_t s;
        case (c)
            C_RTYPE, C_ITYPE, C_SCOND: s = EXEC_ALU;
            C_SH_REG, C_SH_IMM, C_LUI: s = EXEC_SH;
            C_LOAD:                    s = MEM_RD;
            C_STOR:                    s = MEM_WR;
            C_JCOND, C_JAL, C_BCOND:   s = BR_CALC;
            default:                   s = FETCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bus between the sequencer and the datapath.
// master = sequencer, slave = datapath.
interface control_fsm_if;

    logic [3:0] opCode;
    logic [3:0] opCodeExt;
    logic       condTrue;
    logic       memReady;

    logic       instrRegEn;
    logic       regFileEn;
    logic       memDataRegEn;
    logic       outRegEn;
    logic       codesComputed;
    logic       muxMemAdr;
    logic       muxBin;
    logic       muxPc;
    logic       shiftOp;
    logic [1:0] muxAin;
    logic [1:0] muxToRegFile;
    logic [1:0] muxShiftAmount;
    logic [1:0] muxShiftShifter;
    logic [1:0] muxOut;
    logic [1:0] muxExtImm;
    logic [1:0] pcEn;
    logic [4:0] aluOp;
    logic       memWrite;
    logic       illegal;

    modport master (
        input  opCode, opCodeExt, condTrue, memReady,
        output instrRegEn, regFileEn, memDataRegEn,
        output outRegEn, codesComputed,
        output muxMemAdr, muxBin, muxPc, shiftOp,
        output muxAin, muxToRegFile, muxShiftAmount,
        output muxShiftShifter, muxOut, muxExtImm,
        output pcEn, aluOp, memWrite, illegal
    );

    modport slave (
        output opCode, opCodeExt, condTrue, memReady,
        input  instrRegEn, regFileEn, memDataRegEn,
        input  outRegEn, codesComputed,
        input  muxMemAdr, muxBin, muxPc, shiftOp,
        input  muxAin, muxToRegFile, muxShiftAmount,
        input  muxShiftShifter, muxOut, muxExtImm,
        input  pcEn, aluOp, memWrite, illegal
    );

endinterface

// File: rtl/control_fsm_decode.sv
// Combinational instruction classifier.
// Maps opcode/extension to a class and the ALU code it implies.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opCode,
    input  logic [3:0] opCodeExt,
    output decode_t    dec
);

    // Classify the instruction; unknown extensions are illegal.
    always_comb begin
        dec.cls    = C_ILLEGAL;
        dec.alu_op = 5'b00000;
        unique case (opCode)
            OP_RTYPE: begin
                dec.cls    = C_RTYPE;
                dec.alu_op = {1'b0, opCodeExt};
            end
            OP_SHIFT: begin
                if (opCodeExt == EXT_SH_REG)
                    dec.cls = C_SH_REG;
                else if (opCodeExt[3:1] == 3'b000)
                    dec.cls = C_SH_IMM;
            end
            OP_LUI:   dec.cls = C_LUI;
            OP_BCOND: dec.cls = C_BCOND;
            OP_SPECIAL: begin
                case (opCodeExt)
                    EXT_LOAD:  dec.cls = C_LOAD;
                    EXT_STOR:  dec.cls = C_STOR;
                    EXT_JCOND: dec.cls = C_JCOND;
                    EXT_JAL:   dec.cls = C_JAL;
                    EXT_SCOND: dec.cls = C_SCOND;
                    default:   dec.cls = C_ILLEGAL;
                endcase
            end
            default: begin
                dec.cls    = C_ITYPE;
                dec.alu_op = {1'b0, opCode};
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle sequencer for the 16-bit datapath.
// Moore outputs from state and the instruction latched in DECODE.
module control_fsm
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
);

    if (WIDTH < 16) begin : g_width_chk
        $error("control_fsm: WIDTH must hold a 16-bit instruction");
    end

    state_t  state;
    decode_t dec;
    decode_t dec_q;

    instr_decode u_decode (
        .opCode    (bus.opCode),
        .opCodeExt (bus.opCodeExt),
        .dec       (dec)
    );

    // State sequencing; the decoded class is held from DECODE on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            dec_q <= '0;
        end else begin
            unique case (state)
                FETCH:
                    if (bus.memReady) state <= DECODE;
                DECODE: begin
                    dec_q <= dec;
                    state <= exec_state(dec.cls);
                end
                EXEC_ALU:
                    state <= (dec_q.cls != C_SCOND &&
                              dec_q.alu_op == ALU_CMP)
                             ? FETCH : WB;
                EXEC_SH: state <= WB;
                WB:      state <= FETCH;
                MEM_RD:
                    if (bus.memReady) state <= LD_WB;
                LD_WB:   state <= FETCH;
                MEM_WR:
                    if (bus.memReady) state <= FETCH;
                BR_CALC: state <= BR_LOAD;
                BR_LOAD: state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Datapath controls; everything is forced low while in reset.
    always_comb begin
        bus.instrRegEn      = 1'b0;
        bus.regFileEn       = 1'b0;
        bus.memDataRegEn    = 1'b0;
        bus.outRegEn        = 1'b0;
        bus.codesComputed   = 1'b0;
        bus.muxMemAdr       = 1'b0;
        bus.muxBin          = 1'b0;
        bus.muxPc           = 1'b0;
        bus.shiftOp         = 1'b0;
        bus.muxAin          = AIN_PC;
        bus.muxToRegFile    = RF_MEM;
        bus.muxShiftAmount  = AMT_REG;
        bus.muxShiftShifter = SHF_REG;
        bus.muxOut          = OUT_SHIFT;
        bus.muxExtImm       = IMM_SEXT;
        bus.pcEn            = PC_HOLD;
        bus.aluOp           = 5'b00000;
        bus.memWrite        = 1'b0;
        bus.illegal         = 1'b0;
        if (reset) begin
            unique case (state)
                FETCH: begin
                    bus.instrRegEn = bus.memReady;
                    if (bus.memReady) bus.pcEn = PC_ADD;
                end
                DECODE:
                    bus.illegal = (dec.cls == C_ILLEGAL);
                EXEC_ALU: begin
                    bus.muxAin   = AIN_REG;
                    bus.outRegEn = 1'b1;
                    if (dec_q.cls == C_SCOND) begin
                        bus.muxOut = OUT_COND;
                    end else begin
                        bus.muxOut        = OUT_ALU;
                        bus.codesComputed = 1'b1;
                        bus.aluOp         = dec_q.alu_op;
                        bus.muxBin        = (dec_q.cls == C_ITYPE);
                    end
                end
                EXEC_SH: begin
                    bus.outRegEn = 1'b1;
                    if (dec_q.cls == C_SH_IMM) begin
                        bus.muxShiftAmount = AMT_IMM;
                        bus.muxExtImm      = IMM_SHAMT;
                    end else if (dec_q.cls == C_LUI) begin
                        bus.muxShiftShifter = SHF_IMM;
                        bus.muxShiftAmount  = AMT_LUI;
                        bus.muxExtImm       = IMM_UPPER;
                    end
                end
                WB: begin
                    bus.regFileEn    = 1'b1;
                    bus.muxToRegFile = RF_OUT;
                end
                MEM_RD: begin
                    bus.muxMemAdr    = 1'b1;
                    bus.memDataRegEn = bus.memReady;
                end
                LD_WB: begin
                    bus.regFileEn    = 1'b1;
                    bus.muxToRegFile = RF_MEM;
                end
                MEM_WR: begin
                    bus.muxMemAdr = 1'b1;
                    bus.memWrite  = 1'b1;
                end
                BR_CALC: begin
                    bus.aluOp    = ALU_ADD;
                    bus.outRegEn = 1'b1;
                    bus.muxOut   = OUT_ALU;
                    if (dec_q.cls == C_BCOND) begin
                        bus.muxAin = AIN_PC;
                        bus.muxBin = 1'b1;
                    end else begin
                        bus.muxAin = AIN_JTGT;
                    end
                end
                BR_LOAD: begin
                    if (bus.condTrue || dec_q.cls == C_JAL) begin
                        bus.pcEn  = PC_LOAD;
                        bus.muxPc = 1'b1;
                    end
                    // Link register gets the already-incremented PC.
                    if (dec_q.cls == C_JAL) begin
                        bus.regFileEn    = 1'b1;
                        bus.muxToRegFile = RF_LINK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter WIDTH, default 16: datapath word width; the block only uses it for documentation consistency.
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port opCode, input, 4: instruction bits [15:12] from instruction register.
REQ-005 Port opCodeExt, input, 4: instruction bits [7:4].
REQ-006 Port condTrue, input, 1: bit 0 of datapath condition-check result.
REQ-007 Port memReady, input, 1: memory access completes this cycle when 1.
REQ-008 Ports instrRegEn, regFileEn, memDataRegEn, outRegEn, codesComputed, output, 1 each: datapath register write enables.
REQ-009 Ports muxMemAdr, muxBin, muxPc, shiftOp, output, 1 each: datapath selects (0 = PC address / reg operand / +1 / logical).
REQ-010 Ports muxAin, muxToRegFile, muxShiftAmount, muxShiftShifter, muxOut, muxExtImm, output, 2 each: datapath mux selects.
REQ-011 Port pcEn, output, 2: 00 hold, 10 load, 11 add.
REQ-012 Port aluOp, output, 5: ALU operation code.
REQ-013 Port memWrite, output, 1: memory store strobe.
REQ-014 Port illegal, output, 1: one-cycle pulse on undecodable instruction.

Function
REQ-015 States SHALL be: FETCH, DECODE, EXEC_ALU, EXEC_SH, WB, MEM_RD, LD_WB, MEM_WR, BR_CALC, BR_LOAD.
REQ-016 Outputs SHALL be Moore, decoded from state and latched opCode/opCodeExt; every enable not listed for a state SHALL be 0.
REQ-017 FETCH: muxMemAdr=0, instrRegEn=memReady, pcEn=11 with muxPc=0 when memReady, else 00; FETCH->DECODE when memReady, else stay.
REQ-018 DECODE: no enables. Next state by class:
- opCode 0000: R-type, aluOp={0,opCodeExt}, muxBin=0.
- opCode 1000: shift; ext 0100 register amount, ext 000x immediate amount.
- opCode 1111: LUI.
- opCode 0100: special; ext 0000 LOAD, ext 0100 STOR, ext 1100 Jcond, ext 1000 JAL, ext 1101 Scond.
- opCode 1100: Bcond.
- other opCodes except 0100/1000/1100/1111: I-type, aluOp={0,opCode}, muxBin=1, muxExtImm=00.
- any undefined ext: illegal=1 and ->FETCH.
REQ-019 EXEC_ALU: muxAin=01, outRegEn=1, muxOut=01, codesComputed=1; ->WB, except CMP (aluOp 01011) ->FETCH without writeback.
REQ-020 EXEC_SH: shiftOp=0, muxOut=00, outRegEn=1; register shift muxShiftShifter=00/muxShiftAmount=00; LSHI 00/01 with muxExtImm=01; LUI 01/10 with muxExtImm=10; ->WB.
REQ-021 Scond SHALL use EXEC_ALU with muxOut=10, codesComputed=0.
REQ-022 WB: regFileEn=1, muxToRegFile=01; ->FETCH.
REQ-023 MEM_RD: muxMemAdr=1; memDataRegEn=memReady; stay until memReady, then ->LD_WB (regFileEn=1, muxToRegFile=00) ->FETCH.
REQ-024 MEM_WR: muxMemAdr=1, memWrite=1 until memReady, then ->FETCH.
REQ-025 BR_CALC: aluOp=00101 (ADD), outRegEn=1, muxOut=01; Bcond muxAin=00, muxBin=1, muxExtImm=00; Jcond/JAL muxAin=11, muxBin=0; ->BR_LOAD.
REQ-026 BR_LOAD: if condTrue or JAL, pcEn=10, muxPc=1; JAL additionally regFileEn=1, muxToRegFile=10 (return address = incremented PC); ->FETCH.
REQ-027 Latency: R/I/shift 4 cycles, LOAD 4, STOR 3, branch/jump 4, all with memReady=1; each memReady=0 cycle adds one.

Reset
REQ-028 While reset=0: state=FETCH, all outputs 0, pcEn=00; a reset mid-instruction SHALL abandon it with no register or memory write.
REQ-029 First FETCH SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-030 State encoding, opcode/ext constants and aluOp constants SHALL live in shared package cpu_pkg.
REQ-031 Instruction classification SHALL be a combinational sub-module instr_decode feeding the FSM.

Verification
REQ-032 ADD (0000 rd 0101 rs), memReady=1 -> states FETCH, DECODE, EXEC_ALU, WB; regFileEn high only in cycle 4; aluOp=00101.
REQ-033 CMPI (opCode 1011) -> codesComputed=1 in EXEC_ALU, regFileEn never 1, back to FETCH in cycle 4.
REQ-034 LOAD with memReady low 2 cycles in MEM_RD -> memDataRegEn pulses once, in the memReady cycle; total 6 cycles.
REQ-035 Bcond, condTrue=0 -> pcEn=00 in BR_LOAD; condTrue=1 -> pcEn=10, muxPc=1.
REQ-036 JAL -> BR_LOAD has regFileEn=1, muxToRegFile=10, pcEn=10 in same cycle.
REQ-037 reset low during MEM_WR -> memWrite drops immediately; after release FETCH with all enables 0.
